// File: rtl/full_adder_fa_cell.sv
// One-bit combinational full adder; the top module chains these into a
// ripple-carry adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from fa_cell stages, with registered
// sum, carry-out, signed overflow and a valid qualifier (1-cycle latency).
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sum;
  logic             w_carryOut;
  logic             w_carryIntoMsb;
  logic             w_overflow;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_overflow;
  logic             r_outValid;

  // Each stage owns its own carry nets so the chain has no vector self-dependency.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic w_cin;
    logic w_cout;

    if (i == 0) begin : g_first
      assign w_cin = c;
    end else begin : g_next
      assign w_cin = g_stage[i-1].w_cout;
    end

    fa_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_cin),
      .s    (w_sum[i]),
      .cout (w_cout)
    );
  end

  assign w_carryOut     = g_stage[WIDTH-1].w_cout;
  assign w_carryIntoMsb = g_stage[WIDTH-1].w_cin;
  assign w_overflow     = w_carryOut ^ w_carryIntoMsb;

  // Results only load on valid cycles; idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_outValid <= 1'b0;
    end else if (in_valid) begin
      r_sum      <= w_sum;
      r_carry    <= w_carryOut;
      r_overflow <= w_overflow;
      r_outValid <= 1'b1;
    end else begin
      r_outValid <= 1'b0;
    end
  end

  assign sum       = r_sum;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench: three adder instances (WIDTH 1, 8, 16) checked every
// cycle against an arithmetic reference model with 1-cycle latency.
module tb_full_adder;

  typedef struct packed {
    logic        vld;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] aIn [3];
  logic [15:0] bIn [3];
  logic        cIn [3];
  logic        vIn [3];
  logic        rIn [3];

  logic [0:0]  sumW1;
  logic [7:0]  sumW8;
  logic [15:0] sumW16;
  logic        carryO [3];
  logic        ovfO   [3];
  logic        vldO   [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [15:0] holdSum   [3];
  logic        holdCarry [3];
  logic        holdOvf   [3];

  int checks = 0;
  int errors = 0;
  logic drainFlag = 1'b0;
  logic drainDone = 1'b0;

  full_adder #(.WIDTH(1)) u_dutW1 (
    .clk(clk), .rst(rIn[0]), .a(aIn[0][0:0]), .b(bIn[0][0:0]), .c(cIn[0]),
    .in_valid(vIn[0]), .sum(sumW1), .carry(carryO[0]), .overflow(ovfO[0]),
    .out_valid(vldO[0])
  );

  full_adder #(.WIDTH(8)) u_dutW8 (
    .clk(clk), .rst(rIn[1]), .a(aIn[1][7:0]), .b(bIn[1][7:0]), .c(cIn[1]),
    .in_valid(vIn[1]), .sum(sumW8), .carry(carryO[1]), .overflow(ovfO[1]),
    .out_valid(vldO[1])
  );

  full_adder #(.WIDTH(16)) u_dutW16 (
    .clk(clk), .rst(rIn[2]), .a(aIn[2]), .b(bIn[2]), .c(cIn[2]),
    .in_valid(vIn[2]), .sum(sumW16), .carry(carryO[2]), .overflow(ovfO[2]),
    .out_valid(vldO[2])
  );

  function automatic int widthOf(int k);
    return (k == 0) ? 1 : ((k == 1) ? 8 : 16);
  endfunction

  // Reference: plain integer addition, overflow from the signed value range.
  function automatic exp_t refModel(int w, logic [15:0] av, logic [15:0] bv, logic cv);
    longint unsigned mask;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned total;
    longint half;
    longint sa;
    longint sb;
    longint st;
    exp_t e;
    mask  = (64'd1 << w) - 64'd1;
    ua    = {48'd0, av} & mask;
    ub    = {48'd0, bv} & mask;
    total = ua + ub + {63'd0, cv};
    half  = longint'(64'd1 << (w - 1));
    sa    = (longint'(ua) >= half) ? longint'(ua) - 2 * half : longint'(ua);
    sb    = (longint'(ub) >= half) ? longint'(ub) - 2 * half : longint'(ub);
    st    = sa + sb + longint'({63'd0, cv});
    e.vld   = 1'b1;
    e.sum   = 16'(total & mask);
    e.carry = ((total >> w) & 64'd1) != 64'd0;
    e.ovf   = (st > half - 1) || (st < -half);
    return e;
  endfunction

  // Computes the expected post-edge state of every DUT, then queues it at the edge.
  task automatic applyStimulus();
    exp_t e [3];
    for (int k = 0; k < 3; k++) begin
      if (rIn[k]) begin
        e[k] = '0;
        holdSum[k] = '0;
        holdCarry[k] = 1'b0;
        holdOvf[k] = 1'b0;
      end else if (vIn[k]) begin
        e[k] = refModel(widthOf(k), aIn[k], bIn[k], cIn[k]);
        holdSum[k] = e[k].sum;
        holdCarry[k] = e[k].carry;
        holdOvf[k] = e[k].ovf;
      end else begin
        e[k].vld = 1'b0;
        e[k].sum = holdSum[k];
        e[k].carry = holdCarry[k];
        e[k].ovf = holdOvf[k];
      end
    end
    @(posedge clk);
    q0.push_back(e[0]);
    q1.push_back(e[1]);
    q2.push_back(e[2]);
    #1;
  endtask

  task automatic setIdle();
    for (int k = 0; k < 3; k++) begin
      rIn[k] = 1'b0;
      vIn[k] = 1'b0;
      aIn[k] = 16'($urandom());
      bIn[k] = 16'($urandom());
      cIn[k] = 1'($urandom());
    end
  endtask

  task automatic drive(int k, logic [15:0] av, logic [15:0] bv, logic cv);
    setIdle();
    vIn[k] = 1'b1;
    aIn[k] = av;
    bIn[k] = bv;
    cIn[k] = cv;
    applyStimulus();
  endtask

  task automatic checkOutput(int k, exp_t e);
    exp_t act;
    act.vld   = vldO[k];
    act.sum   = (k == 0) ? {15'd0, sumW1} : ((k == 1) ? {8'd0, sumW8} : sumW16);
    act.carry = carryO[k];
    act.ovf   = ovfO[k];
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL w%0d_result: got vld=%0b sum=%h carry=%0b ovf=%0b, want vld=%0b sum=%h carry=%0b ovf=%0b",
               widthOf(k), act.vld, act.sum, act.carry, act.ovf, e.vld, e.sum, e.carry, e.ovf);
    end
  endtask

  // Monitor: one queued expectation per DUT per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q0.size() > 0) checkOutput(0, q0.pop_front());
    if (q1.size() > 0) checkOutput(1, q1.pop_front());
    if (q2.size() > 0) checkOutput(2, q2.pop_front());
    if (drainFlag && !drainDone) begin
      drainDone <= 1'b1;
      checks++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
        errors++;
        $display("[TB] FAIL drain: got %0d pending, want 0", q0.size() + q1.size() + q2.size());
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rIn[k] = 1'b1;
      vIn[k] = 1'b0;
      aIn[k] = '0;
      bIn[k] = '0;
      cIn[k] = 1'b0;
      holdSum[k] = '0;
      holdCarry[k] = 1'b0;
      holdOvf[k] = 1'b0;
    end
    applyStimulus();
    applyStimulus();

    $display("[TB] WIDTH=1 exhaustive");
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      drive(0, {15'd0, vv[2]}, {15'd0, vv[1]}, vv[0]);
    end

    $display("[TB] WIDTH=8 directed");
    drive(1, 16'h00FF, 16'h0000, 1'b1);
    drive(1, 16'h007F, 16'h0001, 1'b0);
    drive(1, 16'h00FF, 16'h00FF, 1'b1);
    drive(1, 16'h0000, 16'h0000, 1'b0);
    drive(1, 16'h0010, 16'h0020, 1'b0);
    setIdle();
    applyStimulus();
    applyStimulus();
    setIdle();
    rIn[1] = 1'b1;
    vIn[1] = 1'b1;
    aIn[1] = 16'h00AA;
    bIn[1] = 16'h0055;
    applyStimulus();
    drive(1, 16'h0001, 16'h0001, 1'b0);
    setIdle();
    applyStimulus();

    $display("[TB] WIDTH=16 directed");
    drive(2, 16'hFFFF, 16'hFFFF, 1'b1);
    drive(2, 16'h0000, 16'h0000, 1'b0);
    drive(2, 16'h7FFF, 16'h0000, 1'b1);
    drive(2, 16'h8000, 16'h8000, 1'b0);

    $display("[TB] random back-to-back");
    for (int n = 0; n < 1000; n++) begin
      setIdle();
      vIn[2] = 1'b1;
      vIn[0] = ($urandom_range(0, 3) != 0);
      vIn[1] = ($urandom_range(0, 3) != 0);
      rIn[1] = ($urandom_range(0, 49) == 0);
      applyStimulus();
    end

    setIdle();
    applyStimulus();
    applyStimulus();
    drainFlag = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
